// File: rtl/console_bus_responder.sv
// Text-console register window on the data bus.
// Turns CHAR/CURSOR/STATUS/CLEAR accesses into framebuffer writes.
module console_bus_responder #(
  parameter logic [63:0] BASE = 64'h0000_0000_0000_F000,
  parameter int          COLS = 80,
  parameter int          ROWS = 25,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [63:0] address,
  input  logic [63:0] dataIn,
  input  logic        read,
  input  logic        write,
  output logic [63:0] dataOut,
  output logic        readValid,
  output logic [10:0] fbAddress,
  output logic [7:0]  fbData,
  output logic        fbWrite,
  input  logic [7:0]  fbReadData,
  output logic        busy
);

  localparam int          CELLS = COLS * ROWS;
  localparam logic [10:0] LAST  = 11'(CELLS - 1);
  localparam logic [11:0] DONE  = 12'(CELLS);

  typedef enum logic [1:0] {
    IDLE,
    RDWAIT,
    CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cursor_q, cursor_d;
  logic        wrapped_q, wrapped_d;
  logic [11:0] clrIdx_q, clrIdx_d;
  logic        busy_q, busy_d;
  logic [1:0]  rdOff_q, rdOff_d;
  logic [63:0] dataOut_q, dataOut_d;
  logic        readValid_q, readValid_d;
  logic [10:0] fbAddr_q, fbAddr_d;
  logic [7:0]  fbData_q, fbData_d;
  logic        fbWrite_q, fbWrite_d;

  logic        hit;
  logic [1:0]  off;
  logic        st;
  logic        ld;
  logic        step;
  logic [10:0] wAddr;
  logic [63:0] rdRes;
  logic        unused_bits;

  assign hit = (address[63:5] == BASE[63:5]);
  assign off = address[4:3];
  assign st  = hit & write;
  assign ld  = hit & read & ~write;

  assign unused_bits = ^{address[2:0], dataIn[63:11]};

  always_comb begin
    rdRes = '0;
    unique case (rdOff_q)
      2'd0: rdRes = {56'd0, fbReadData};
      2'd1: rdRes = {53'd0, cursor_q};
      2'd2: rdRes = {62'd0, wrapped_q, busy_q};
      2'd3: rdRes = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    wrapped_d   = wrapped_q;
    clrIdx_d    = clrIdx_q;
    busy_d      = busy_q;
    rdOff_d     = rdOff_q;
    dataOut_d   = dataOut_q;
    readValid_d = 1'b0;
    fbWrite_d   = 1'b0;
    fbData_d    = fbData_q;
    wAddr       = '0;
    step        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld) begin
          state_d = RDWAIT;
          rdOff_d = off;
        end
      end
      RDWAIT: begin
        readValid_d = 1'b1;
        dataOut_d   = rdRes;
        state_d     = busy_q ? CLEAR : IDLE;
        step        = busy_q;
      end
      CLEAR: begin
        if (ld) begin
          state_d = RDWAIT;
          rdOff_d = off;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // clrIdx runs one past the last cell so busy covers the final write
    if (step) begin
      if (clrIdx_q == DONE) begin
        busy_d   = 1'b0;
        clrIdx_d = '0;
        state_d  = IDLE;
      end else begin
        fbWrite_d = 1'b1;
        wAddr     = clrIdx_q[10:0];
        fbData_d  = FILL;
        clrIdx_d  = clrIdx_q + 12'd1;
      end
    end

    if (st) begin
      unique case (off)
        2'd0: begin
          if (!busy_q) begin
            fbWrite_d = 1'b1;
            wAddr     = cursor_q;
            fbData_d  = dataIn[7:0];
            if (cursor_q == LAST) begin
              cursor_d  = '0;
              wrapped_d = 1'b1;
            end else begin
              cursor_d = cursor_q + 11'd1;
            end
          end
        end
        2'd1: begin
          if (!busy_q && dataIn[10:0] <= LAST)
            cursor_d = dataIn[10:0];
        end
        2'd2: begin
          if (dataIn[1])
            wrapped_d = 1'b0;
        end
        2'd3: begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          cursor_d  = '0;
          clrIdx_d  = 12'd1;
          fbWrite_d = 1'b1;
          wAddr     = '0;
          fbData_d  = FILL;
        end
      endcase
    end

    // idle cycles park the cursor on the bus so a CHAR load reads in time
    fbAddr_d = fbWrite_d ? wAddr : cursor_d;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      wrapped_q   <= 1'b0;
      clrIdx_q    <= '0;
      busy_q      <= 1'b0;
      rdOff_q     <= '0;
      dataOut_q   <= '0;
      readValid_q <= 1'b0;
      fbAddr_q    <= '0;
      fbData_q    <= '0;
      fbWrite_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      wrapped_q   <= wrapped_d;
      clrIdx_q    <= clrIdx_d;
      busy_q      <= busy_d;
      rdOff_q     <= rdOff_d;
      dataOut_q   <= dataOut_d;
      readValid_q <= readValid_d;
      fbAddr_q    <= fbAddr_d;
      fbData_q    <= fbData_d;
      fbWrite_q   <= fbWrite_d;
    end
  end

  assign dataOut   = dataOut_q;
  assign readValid = readValid_q;
  assign fbAddress = fbAddr_q;
  assign fbData    = fbData_q;
  assign fbWrite   = fbWrite_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_console_bus_responder.sv
// Bench for console_bus_responder: directed steps with random data,
// checked against a cursor/array model of the console.
module tb_console_bus_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_0000_F000;
  localparam int          CELLS = 2000;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [63:0] address = '0;
  logic [63:0] dataIn = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [63:0] dataOut;
  logic        readValid;
  logic [10:0] fbAddress;
  logic [7:0]  fbData;
  logic        fbWrite;
  logic [7:0]  fbReadData;
  logic        busy;

  console_bus_responder dut (
    .clock      (clock),
    .resetN     (resetN),
    .address    (address),
    .dataIn     (dataIn),
    .read       (read),
    .write      (write),
    .dataOut    (dataOut),
    .readValid  (readValid),
    .fbAddress  (fbAddress),
    .fbData     (fbData),
    .fbWrite    (fbWrite),
    .fbReadData (fbReadData),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // framebuffer: 1-cycle read latency
  logic [7:0] ram [2048];
  always @(posedge clock) begin
    if (fbWrite) ram[fbAddress] <= fbData;
    fbReadData <= ram[fbAddress];
  end

  // cumulative tallies of activity while busy
  int busy_cnt = 0;
  int clr_wr   = 0;
  int clr_bad  = 0;
  int cellcnt [2048];
  always @(negedge clock) begin
    if (busy) begin
      busy_cnt++;
      if (fbWrite) begin
        clr_wr++;
        if (fbData == 8'h20) cellcnt[fbAddress]++;
        else clr_bad++;
      end
    end
  end

  // reference model
  int         cur_m  = 0;
  bit         wrap_m = 1'b0;
  bit         busy_m = 1'b0;
  logic [7:0] mem_m [2048];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] model_rd(input int off);
    case (off)
      0:       return {56'd0, mem_m[cur_m]};
      1:       return 64'(cur_m);
      2:       return {62'd0, wrap_m, busy_m};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] reg_addr(input int off);
    return BASE + 64'(off * 8) + 64'($urandom_range(0, 7));
  endfunction

  task automatic store(input int off, input logic [63:0] d);
    int old;
    old = cur_m;
    address = reg_addr(off);
    dataIn  = d;
    write   = 1'b1;
    tick();
    write   = 1'b0;
    address = '0;
    case (off)
      0: if (!busy_m) begin
        chk("char_we", fbWrite, 1);
        chk("char_addr", fbAddress, 64'(old));
        chk("char_data", fbData, d[7:0]);
        mem_m[old] = d[7:0];
        cur_m = cur_m + 1;
        if (cur_m == CELLS) begin
          cur_m  = 0;
          wrap_m = 1'b1;
        end
      end
      1: begin
        if (!busy_m) chk("cur_no_we", fbWrite, 0);
        if (!busy_m && int'(d[10:0]) < CELLS) cur_m = int'(d[10:0]);
      end
      2: begin
        if (!busy_m) chk("stat_no_we", fbWrite, 0);
        if (d[1]) wrap_m = 1'b0;
      end
      default: begin
        chk("clr_we", fbWrite, 1);
        chk("clr_addr", fbAddress, 0);
        chk("clr_data", fbData, 8'h20);
        chk("clr_busy", busy, 1);
        busy_m = 1'b1;
        cur_m  = 0;
      end
    endcase
  endtask

  task automatic load(input int off, input string tag);
    logic [63:0] exp;
    exp = model_rd(off);
    address = reg_addr(off);
    read = 1'b1;
    tick();
    read = 1'b0;
    address = '0;
    chk({tag, "_rv_n1"}, readValid, 0);
    tick();
    chk({tag, "_rv_n2"}, readValid, 1);
    chk(tag, dataOut, exp);
    tick();
    chk({tag, "_rv_n3"}, readValid, 0);
  endtask

  task automatic wait_clear(input string tag);
    for (int i = 0; i < 2200 && busy; i++) tick();
    chk({tag, "_done"}, busy, 0);
    busy_m = 1'b0;
    for (int i = 0; i < 2048; i++) mem_m[i] = 8'h20;
  endtask

  function automatic int cells_not(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++)
      if (cellcnt[i] != n) bad++;
    return bad;
  endfunction

  initial begin
    int b0;
    int w0;
    logic [7:0] c;

    repeat (3) tick();
    chk("rst_dataOut", dataOut, 0);
    chk("rst_rv", readValid, 0);
    chk("rst_we", fbWrite, 0);
    chk("rst_addr", fbAddress, 0);
    chk("rst_data", fbData, 0);
    chk("rst_busy", busy, 0);
    resetN = 1'b1;
    tick();

    // back-to-back CHAR stores
    address = BASE;
    dataIn = 64'h41;
    write = 1'b1;
    tick();
    chk("b2b_we0", fbWrite, 1);
    chk("b2b_a0", fbAddress, 0);
    chk("b2b_d0", fbData, 8'h41);
    dataIn = 64'h42;
    tick();
    chk("b2b_we1", fbWrite, 1);
    chk("b2b_a1", fbAddress, 1);
    chk("b2b_d1", fbData, 8'h42);
    write = 1'b0;
    address = '0;
    tick();
    chk("b2b_idle", fbWrite, 0);
    mem_m[0] = 8'h41;
    mem_m[1] = 8'h42;
    cur_m = 2;
    load(1, "cursor_2");

    repeat (6) store(0, 64'($urandom_range(33, 126)));
    store(1, 3);
    load(0, "char_at3");

    // wrap at the last cell
    store(1, 1999);
    store(0, 64'h5A);
    load(1, "cursor_wrap");
    load(2, "status_wrap");
    store(2, 64'h2);
    load(2, "status_clr");

    store(1, 2000);
    load(1, "cursor_2000");
    store(1, 64'($urandom_range(2000, 2047)));
    load(1, "cursor_big");
    store(1, 64'hFFFF_0000_0000_0007);
    load(1, "cursor_hibits");

    store(1, 5);
    store(0, 64'h33);
    store(1, 5);
    load(0, "char_33");

    // read and write together: write wins
    c = 8'($urandom_range(65, 90));
    address = BASE;
    dataIn = {56'd0, c};
    read = 1'b1;
    write = 1'b1;
    tick();
    read = 1'b0;
    write = 1'b0;
    address = '0;
    chk("rw_we", fbWrite, 1);
    chk("rw_addr", fbAddress, 64'(cur_m));
    chk("rw_data", fbData, c);
    mem_m[cur_m] = c;
    cur_m = cur_m + 1;
    tick();
    chk("rw_rv1", readValid, 0);
    tick();
    chk("rw_rv2", readValid, 0);

    // accesses outside the window
    address = BASE + 64'h40;
    dataIn = 64'h77;
    write = 1'b1;
    tick();
    write = 1'b0;
    chk("miss_we", fbWrite, 0);
    read = 1'b1;
    tick();
    read = 1'b0;
    address = '0;
    tick();
    chk("miss_rv", readValid, 0);
    load(1, "cursor_miss");

    // uninterrupted clear
    b0 = busy_cnt;
    w0 = clr_wr;
    store(3, 64'($urandom));
    wait_clear("clr1");
    chk("clr1_busy_cycles", 64'(busy_cnt - b0), 2000);
    chk("clr1_writes", 64'(clr_wr - w0), 2000);
    chk("clr1_cells", 64'(cells_not(1)), 0);
    load(0, "char_after_clr");

    // clear with a dropped store and a paused load
    b0 = busy_cnt;
    w0 = clr_wr;
    store(3, 64'd0);
    repeat ($urandom_range(10, 500)) tick();
    store(0, 64'($urandom_range(65, 90)));
    repeat ($urandom_range(10, 500)) tick();
    load(2, "status_busy");
    wait_clear("clr2");
    chk("clr2_busy_cycles", 64'(busy_cnt - b0), 2001);
    chk("clr2_writes", 64'(clr_wr - w0), 2000);
    chk("clr2_cells", 64'(cells_not(2)), 0);
    chk("clr_bad_data", 64'(clr_bad), 0);
    load(1, "cursor_after_clr");

    // asynchronous reset mid-clear
    store(3, 64'd1);
    repeat (50) tick();
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", fbWrite, 0);
    busy_m = 1'b0;
    cur_m  = 0;
    wrap_m = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    load(2, "status_arst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
